// File: rtl/ringbuffer_drain_if.sv
// Ring buffer drain bus: pop side toward the ring buffer,
// byte stream toward the serial transmitter.
interface ringbuffer_drain_if #(
  parameter int DW = 48
);
  logic          i_en;
  logic          i_rb_empty;
  logic          i_rb_overflow;
  logic [DW-1:0] i_rb_read_data;
  logic          o_rb_read_en;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_busy;

  modport master (
    input  i_en,
    input  i_rb_empty,
    input  i_rb_overflow,
    input  i_rb_read_data,
    input  i_tx_ready,
    output o_rb_read_en,
    output o_tx_data,
    output o_tx_valid,
    output o_busy
  );

  modport slave (
    output i_en,
    output i_rb_empty,
    output i_rb_overflow,
    output i_rb_read_data,
    output i_tx_ready,
    input  o_rb_read_en,
    input  o_tx_data,
    input  o_tx_valid,
    input  o_busy
  );
endinterface

// File: rtl/ringbuffer_drain.sv
// Pops one ring buffer entry at a time and frames it as
// a header byte followed by the entry, MSB byte first.
module ringbuffer_drain #(
  parameter int         DW      = 48,
  parameter logic [7:0] HDR_OK  = 8'h5A,
  parameter logic [7:0] HDR_OVF = 8'h5B
) (
  input  logic i_clock,
  input  logic i_reset,
  ringbuffer_drain_if.master bus
);

  localparam int NB = DW / 8;
  localparam int IW = $clog2(NB) + 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_HDR   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [DW-1:0] r_shift;
  logic [IW-1:0] r_idx;
  logic          r_sticky;
  logic          r_hdr_ovf;
  logic          r_rd_en;
  logic          r_tx_valid;
  logic          r_busy;
  logic          w_hdr_acc;
  logic          w_dat_acc;

  assign w_hdr_acc = (r_state == S_HDR) && bus.i_tx_ready;
  assign w_dat_acc = (r_state == S_DATA) && bus.i_tx_ready;

  // Next-state: frames only start from IDLE and never abort.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_en && !bus.i_rb_empty)
          w_next = S_POP;
      end
      S_POP:   w_next = S_FETCH;
      S_FETCH: w_next = S_HDR;
      S_HDR: begin
        if (bus.i_tx_ready)
          w_next = S_DATA;
      end
      S_DATA: begin
        if (bus.i_tx_ready && r_idx == LAST)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered decodes of the next state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_en    <= (w_next == S_POP);
      r_tx_valid <= (w_next == S_HDR) || (w_next == S_DATA);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  // Entry capture, header choice and byte shifting.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift   <= '0;
      r_idx     <= '0;
      r_hdr_ovf <= 1'b0;
    end else if (r_state == S_FETCH) begin
      r_shift   <= bus.i_rb_read_data;
      r_idx     <= '0;
      r_hdr_ovf <= r_sticky || bus.i_rb_overflow;
    end else if (w_hdr_acc) begin
      r_idx <= '0;
    end else if (w_dat_acc) begin
      r_shift <= r_shift << 8;
      r_idx   <= r_idx + IW'(1);
    end
  end

  // Sticky overflow: cleared only by sending an overflow header.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      r_sticky <= 1'b0;
    else if (bus.i_rb_overflow)
      r_sticky <= 1'b1;
    else if (w_hdr_acc && r_hdr_ovf)
      r_sticky <= 1'b0;
  end

  // Byte mux; header is frozen at HDR entry so it holds under stall.
  always_comb begin
    bus.o_tx_data = 8'h00;
    if (r_state == S_HDR)
      bus.o_tx_data = r_hdr_ovf ? HDR_OVF : HDR_OK;
    else if (r_state == S_DATA)
      bus.o_tx_data = r_shift[DW-1 -: 8];
  end

  assign bus.o_rb_read_en = r_rd_en;
  assign bus.o_tx_valid   = r_tx_valid;
  assign bus.o_busy       = r_busy;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain with a small ring
// buffer model and a byte collector on the tx side.
module tb_ringbuffer_drain;

  localparam int DW = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ringbuffer_drain_if #(.DW(DW)) bus ();

  ringbuffer_drain #(.DW(DW)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.master)
  );

  logic [DW-1:0] mem [16];
  logic [3:0]    wr_ptr = 4'd0;
  logic [3:0]    rd_ptr = 4'd0;
  logic [7:0]    rx [256];
  int            rx_cyc [256];
  int            pop_cyc [64];
  int            rx_n;
  int            pop_n;
  int            cyc;
  int            n_cmp;
  int            n_bad;

  assign bus.i_rb_empty = (wr_ptr == rd_ptr);

  // Ring buffer read port and tx byte collector.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_rb_read_en) begin
      bus.i_rb_read_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
      pop_cyc[pop_n[5:0]] <= cyc;
      pop_n <= pop_n + 1;
    end
    if (rst_n && bus.o_tx_valid && bus.i_tx_ready) begin
      rx[rx_n[7:0]] <= bus.o_tx_data;
      rx_cyc[rx_n[7:0]] <= cyc;
      rx_n <= rx_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_rx(input int target, input string tag);
    for (int i = 0; i < 300 && rx_n < target; i++)
      step();
    chk({tag, "_count"}, 64'(rx_n), 64'(target));
  endtask

  task automatic wait_rx_eq(input int target, input string tag);
    for (int i = 0; i < 100 && rx_n != target; i++)
      step();
    chk({tag, "_sync"}, 64'(rx_n), 64'(target));
  endtask

  task automatic chk_frame(input int base,
                           input logic [7:0] hdr,
                           input logic [DW-1:0] d,
                           input string tag);
    int k;
    chk({tag, "_hdr"}, 64'(rx[base[7:0]]), 64'(hdr));
    for (int i = 0; i < DW / 8; i++) begin
      k = base + 1 + i;
      chk($sformatf("%s_b%0d", tag, i),
          64'(rx[k[7:0]]), 64'(d[DW-1-8*i -: 8]));
    end
  endtask

  int b;
  int p;

  initial begin
    bus.i_en = 1'b0;
    bus.i_rb_overflow = 1'b0;
    bus.i_tx_ready = 1'b0;
    bus.i_rb_read_data = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 64'(bus.o_rb_read_en), 64'd0);
    chk("rst_valid", 64'(bus.o_tx_valid), 64'd0);
    chk("rst_data", 64'(bus.o_tx_data), 64'h00);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // single entry
    bus.i_en = 1'b1;
    bus.i_tx_ready = 1'b1;
    b = rx_n;
    p = pop_n;
    push(48'h0123456789AB);
    wait_rx(b + 7, "single");
    chk("single_busy", 64'(bus.o_busy), 64'd0);
    chk("single_pops", 64'(pop_n), 64'(p + 1));
    chk_frame(b, 8'h5A, 48'h0123456789AB, "single");

    // empty buffer: no pops
    p = pop_n;
    repeat (20) step();
    chk("empty_pops", 64'(pop_n), 64'(p));
    chk("empty_busy", 64'(bus.o_busy), 64'd0);
    chk("empty_valid", 64'(bus.o_tx_valid), 64'd0);

    // backpressure on byte 0x45
    b = rx_n;
    push(48'h0123456789AB);
    wait_rx_eq(b + 3, "bp");
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", i),
          64'(bus.o_tx_valid), 64'd1);
      chk($sformatf("bp_data%0d", i),
          64'(bus.o_tx_data), 64'h45);
    end
    @(posedge clk);
    #1;
    chk("bp_held", 64'(rx_n), 64'(b + 3));
    bus.i_tx_ready = 1'b1;
    wait_rx(b + 7, "bp");
    chk_frame(b, 8'h5A, 48'h0123456789AB, "bp");

    // overflow before pop, then clean frame
    bus.i_rb_overflow = 1'b1;
    step();
    bus.i_rb_overflow = 1'b0;
    b = rx_n;
    push(48'hFEDCBA987654);
    wait_rx(b + 7, "ovf1");
    chk_frame(b, 8'h5B, 48'hFEDCBA987654, "ovf1");
    b = rx_n;
    push(48'h001122334455);
    wait_rx(b + 7, "ovf2");
    chk_frame(b, 8'h5A, 48'h001122334455, "ovf2");

    // overflow coincident with 5B header accept
    bus.i_rb_overflow = 1'b1;
    step();
    bus.i_rb_overflow = 1'b0;
    b = rx_n;
    push(48'hA0A1A2A3A4A5);
    for (int i = 0; i < 20 && !bus.o_tx_valid; i++)
      step();
    chk("ovf3_in_hdr", 64'(bus.o_tx_data), 64'h5B);
    bus.i_rb_overflow = 1'b1;
    step();
    bus.i_rb_overflow = 1'b0;
    chk("ovf3_hdr_acc", 64'(rx_n), 64'(b + 1));
    wait_rx(b + 7, "ovf3");
    chk_frame(b, 8'h5B, 48'hA0A1A2A3A4A5, "ovf3");
    b = rx_n;
    push(48'hB0B1B2B3B4B5);
    wait_rx(b + 7, "ovf4");
    chk_frame(b, 8'h5B, 48'hB0B1B2B3B4B5, "ovf4");
    b = rx_n;
    push(48'hC0C1C2C3C4C5);
    wait_rx(b + 7, "ovf5");
    chk_frame(b, 8'h5A, 48'hC0C1C2C3C4C5, "ovf5");

    // back-to-back, three entries
    b = rx_n;
    p = pop_n;
    push(48'h111111111111);
    step();
    push(48'h222222222222);
    step();
    push(48'h333333333333);
    wait_rx(b + 21, "b2b");
    chk("b2b_pops", 64'(pop_n), 64'(p + 3));
    chk("b2b_period1",
        64'(pop_cyc[(p + 1) % 64] - pop_cyc[p % 64]), 64'd10);
    chk("b2b_period2",
        64'(pop_cyc[(p + 2) % 64] - pop_cyc[p % 64]), 64'd20);
    chk("b2b_span",
        64'(rx_cyc[(b + 20) % 256] - pop_cyc[p % 64]), 64'd28);
    chk("b2b_busy", 64'(bus.o_busy), 64'd0);
    chk_frame(b, 8'h5A, 48'h111111111111, "b2b0");
    chk_frame(b + 7, 8'h5A, 48'h222222222222, "b2b1");
    chk_frame(b + 14, 8'h5A, 48'h333333333333, "b2b2");

    // en dropped mid-frame
    b = rx_n;
    p = pop_n;
    push(48'hDEADBEEF0001);
    step();
    push(48'hDEADBEEF0002);
    wait_rx_eq(b + 2, "en");
    bus.i_en = 1'b0;
    wait_rx(b + 7, "en");
    repeat (15) step();
    chk("en_pops", 64'(pop_n), 64'(p + 1));
    chk("en_bytes", 64'(rx_n), 64'(b + 7));
    chk("en_busy", 64'(bus.o_busy), 64'd0);
    chk_frame(b, 8'h5A, 48'hDEADBEEF0001, "en0");
    bus.i_en = 1'b1;
    wait_rx(b + 14, "en1");
    chk_frame(b + 7, 8'h5A, 48'hDEADBEEF0002, "en1");

    // reset mid-frame
    b = rx_n;
    push(48'h5555AAAA5555);
    wait_rx_eq(b + 4, "mrst");
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.o_tx_valid), 64'd0);
    chk("mrst_busy", 64'(bus.o_busy), 64'd0);
    chk("mrst_data", 64'(bus.o_tx_data), 64'h00);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("mrst_nobytes", 64'(rx_n), 64'(b + 4));
    chk("mrst_idle", 64'(bus.o_busy), 64'd0);
    b = rx_n;
    push(48'h13579BDF2468);
    wait_rx(b + 7, "post");
    chk_frame(b, 8'h5A, 48'h13579BDF2468, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ringbuffer_drain.md
RINGBUFFER_DRAIN -- requirements
Module: ringbuffer_drain

Interface
REQ-001 Parameter DW, default 48: ring buffer entry width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter HDR_OK, default 8'h5A: frame header byte when no overflow is pending.
REQ-003 Parameter HDR_OVF, default 8'h5B: frame header byte when an overflow is pending.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  drain enable; low = start no new frame.
REQ-007 rb_empty  in  1  ring buffer empty flag.
REQ-008 rb_overflow  in  1  ring buffer overflow flag.
REQ-009 rb_read_data  in  DW  ring buffer read data.
REQ-010 rb_read_en  out  1  one-cycle pop strobe to the ring buffer.
REQ-011 tx_data  out  8  byte to the serial transmitter.
REQ-012 tx_valid  out  1  tx_data is valid.
REQ-013 tx_ready  in  1  transmitter accepts the byte this cycle.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, POP, FETCH, HDR and DATA.
REQ-016 IDLE: if en=1 and rb_empty=0, go to POP; otherwise stay in IDLE.
REQ-017 POP: rb_read_en=1 for exactly this one cycle; then go to FETCH unconditionally.
REQ-018 rb_read_en SHALL be 0 in all states except POP, and POP SHALL be entered only when rb_empty=0.
REQ-019 FETCH: capture rb_read_data into a DW-bit shift register (data valid one cycle after rb_read_en); then go to HDR.
REQ-020 HDR: tx_valid=1; tx_data = HDR_OVF if the sticky overflow flag is set, else HDR_OK.
REQ-021 HDR: on tx_valid&tx_ready, go to DATA with byte index 0.
REQ-022 DATA: tx_valid=1; tx_data = shift register bits [DW-1:DW-8], so the entry is sent MSB byte first.
REQ-023 DATA, on each accept: shift left by 8 and increment the byte index.
REQ-024 DATA: the accept of byte DW/8-1 returns the block to IDLE.
REQ-025 While tx_valid=1 and tx_ready=0, tx_data and the state SHALL hold stable.
REQ-026 tx_valid SHALL be 0 in IDLE, POP and FETCH.
REQ-027 Frame = 1 + DW/8 bytes (7 at default DW).
REQ-028 Minimum frame period = 3 + 1 + DW/8 cycles with tx_ready tied high (10 at default), including 1 IDLE cycle between back-to-back frames.
REQ-029 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the IDLE->POP transition.
REQ-030 Sticky overflow flag: set on any rising clock edge where rb_overflow=1; cleared when an HDR byte is accepted with the flag set.
REQ-031 If set and clear coincide on the same edge, set SHALL win.
REQ-032 The byte index SHALL be sized ceil(log2(DW/8))+1 bits and never wrap within a frame.
REQ-033 busy SHALL be a registered state decode: high from the first POP cycle through the final accepted DATA byte, low in IDLE.

Reset
REQ-034 On reset low, immediately: state=IDLE; rb_read_en=0; tx_valid=0; tx_data=8'h00; busy=0; sticky flag=0; shift register=0; byte index=0.
REQ-035 Reset asserted mid-frame SHALL discard the in-flight frame; the already-popped entry is lost, and no partial-frame bytes are emitted after reset release.
REQ-036 After reset release, the first frame SHALL start no earlier than the first rising edge with en=1 and rb_empty=0.

Verification
REQ-037 Single entry: en=1, rb_empty=0 for one pop, rb_read_data=48'h0123456789AB, tx_ready=1 -> one rb_read_en pulse; tx bytes 5A,01,23,45,67,89,AB; busy low after the last byte.
REQ-038 Backpressure: tx_ready low for 5 cycles during byte 3 -> tx_data holds 45 with tx_valid=1 for the whole stall; byte sequence unchanged.
REQ-039 Overflow: pulse rb_overflow for one cycle before a pop -> header 5B; the next frame's header is 5A. Also pulse rb_overflow in the exact cycle the 5B header is accepted -> the next header is still 5B.
REQ-040 Back-to-back and empty: 3 entries queued, tx_ready=1 -> 21 bytes over 30 cycles and exactly 3 rb_read_en pulses. rb_empty=1 throughout -> rb_read_en never asserted.
REQ-041 Enable and reset: drop en during byte 2 -> the frame completes and no further pop occurs. Assert reset during byte 4 -> tx_valid=0 and busy=0 immediately; the next frame starts with a header.
